// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the TicTacToe screen path: sequencer state encoding
// and winner codes, also consumed by the win-screen generator.
package screen_sequencer_pkg;

  localparam logic [1:0] STATE_IDLE     = 2'd0;
  localparam logic [1:0] STATE_PLAY     = 2'd1;
  localparam logic [1:0] STATE_WIN_SHOW = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = STATE_IDLE,
    PLAY     = STATE_PLAY,
    WIN_SHOW = STATE_WIN_SHOW
  } state_t;

  localparam logic [1:0] WIN_DRAW = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;

  // The reserved code 11 is shown as a draw.
  function automatic logic [1:0] sanitize_winner(input logic [1:0] w);
    return (w == 2'b11) ? WIN_DRAW : w;
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game-flow bus between the board/timing logic (master) and the screen
// sequencer (slave).
interface screen_sequencer_if;
  logic       frame_tick;
  logic       btn_start;
  logic       game_over;
  logic [1:0] winner;
  logic       cePS;
  logic       ceSS;
  logic [1:0] winner_q;
  logic       new_game;

  modport master (
    output frame_tick, btn_start, game_over, winner,
    input  cePS, ceSS, winner_q, new_game
  );

  modport slave (
    input  frame_tick, btn_start, game_over, winner,
    output cePS, ceSS, winner_q, new_game
  );
endinterface

// File: rtl/screen_sequencer_rise_detect.sv
// Rising-edge detector for a debounced level input. History resets to 1 so a
// level already high when reset releases is not reported as an edge.
module screen_sequencer_rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) r_prev <= 1'b1;
    else          r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow sequencer: blank -> play -> win screen -> blank, switching only on
// frame boundaries, with a latched winner and a one-cycle board-clear pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | blank screen, waiting for a start request
// PLAY     | play screen shown, waiting for a game-over request
// WIN_SHOW | win screen held for WIN_FRAMES frames or until a new start
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int WIN_FRAMES = 180,
  parameter int CNT_W      = 8
) (
  input logic                clk,
  input logic                reset_n,
  screen_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(WIN_FRAMES - 1);

  state_t           r_state, w_state_nxt;
  logic             r_pend_play, w_pend_play_nxt;
  logic             r_pend_win, w_pend_win_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_winner_q, w_winner_nxt;
  logic             r_ce_ps, r_ce_ss, r_new_game, w_new_game_nxt;
  logic             w_start_edge;

  screen_sequencer_rise_detect u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (bus.btn_start),
    .o_rise  (w_start_edge)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_play_nxt = r_pend_play;
    w_pend_win_nxt  = r_pend_win;
    w_cnt_nxt       = r_cnt;
    w_winner_nxt    = r_winner_q;
    w_new_game_nxt  = 1'b0;

    // Transitions act only on registered requests, so a request raised in a
    // tick cycle waits for the following frame.
    if (bus.frame_tick) begin
      case (r_state)
        IDLE: begin
          if (r_pend_play) begin
            w_state_nxt     = PLAY;
            w_pend_play_nxt = 1'b0;
            w_new_game_nxt  = 1'b1;
          end
        end
        PLAY: begin
          if (r_pend_win) begin
            w_state_nxt    = WIN_SHOW;
            w_pend_win_nxt = 1'b0;
            w_cnt_nxt      = '0;
          end
        end
        WIN_SHOW: begin
          if (r_pend_play) begin
            w_state_nxt     = PLAY;
            w_pend_play_nxt = 1'b0;
            w_new_game_nxt  = 1'b1;
          end else if (r_cnt == LAST_FRAME) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (w_start_edge && (r_state == IDLE || r_state == WIN_SHOW) &&
        (w_state_nxt != PLAY))
      w_pend_play_nxt = 1'b1;

    // First game_over wins; later ones are ignored until the win screen shows.
    if (bus.game_over && (r_state == PLAY) && !r_pend_win) begin
      w_pend_win_nxt = 1'b1;
      w_winner_nxt   = sanitize_winner(bus.winner);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pend_play <= 1'b0;
      r_pend_win  <= 1'b0;
      r_cnt       <= '0;
      r_winner_q  <= WIN_DRAW;
      r_ce_ps     <= 1'b0;
      r_ce_ss     <= 1'b0;
      r_new_game  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_play <= w_pend_play_nxt;
      r_pend_win  <= w_pend_win_nxt;
      r_cnt       <= w_cnt_nxt;
      r_winner_q  <= w_winner_nxt;
      r_ce_ps     <= (w_state_nxt == PLAY);
      r_ce_ss     <= (w_state_nxt == WIN_SHOW);
      r_new_game  <= w_new_game_nxt;
    end
  end

  assign bus.cePS     = r_ce_ps;
  assign bus.ceSS     = r_ce_ss;
  assign bus.winner_q = r_winner_q;
  assign bus.new_game = r_new_game;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenarios on a fixed 20-clock frame,
// then randomized traffic checked against a frame-level behavioural model.
module tb_screen_sequencer;
  localparam int WF = 4;
  localparam int FP = 20;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  screen_sequencer_if sif ();

  screen_sequencer #(.WIN_FRAMES(WF), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif.slave)
  );

  int checks   = 0;
  int failures = 0;

  int frame_ctr = 0;
  bit rand_tick = 1'b0;
  bit last_tick = 1'b0;
  bit btn_lvl   = 1'b0;

  // model: screen 0 blank, 1 play, 2 win; m_left = win frames still to show
  int         m_screen;
  bit         m_play_req, m_win_req;
  int         m_left;
  logic [1:0] m_winner;
  bit         m_ng;
  bit         m_btn_prev;

  logic [4:0] obs;
  assign obs = {sif.cePS, sif.ceSS, sif.winner_q, sif.new_game};

  function automatic logic [4:0] exp_vec();
    return {m_screen == 1, m_screen == 2, m_winner, m_ng};
  endfunction

  task automatic model_update(input bit tick, input bit btn, input bit go,
                              input logic [1:0] w, input bit rst_n);
    int old_screen;
    bit old_wreq, to_play, rise;
    if (!rst_n) begin
      m_screen = 0; m_play_req = 0; m_win_req = 0; m_left = 0;
      m_winner = 2'b00; m_ng = 0; m_btn_prev = 1;
      return;
    end
    old_screen = m_screen;
    old_wreq   = m_win_req;
    to_play    = 0;
    rise       = btn && !m_btn_prev;
    m_btn_prev = btn;
    m_ng       = 0;
    if (tick) begin
      if (old_screen != 1 && m_play_req) begin
        m_screen = 1; m_ng = 1; m_play_req = 0; to_play = 1;
      end else if (old_screen == 1 && m_win_req) begin
        m_screen = 2; m_left = WF; m_win_req = 0;
      end else if (old_screen == 2) begin
        m_left = m_left - 1;
        if (m_left == 0) m_screen = 0;
      end
    end
    if (rise && old_screen != 1 && !to_play) m_play_req = 1;
    if (go && old_screen == 1 && !old_wreq) begin
      m_win_req = 1;
      m_winner  = (w == 2'b11) ? 2'b00 : w;
    end
  endtask

  task automatic step(input bit btn, input bit go, input logic [1:0] w, input bit rst_n);
    bit tick;
    if (rand_tick) tick = ($urandom_range(0, 7) == 0);
    else           tick = (frame_ctr == FP - 1);
    frame_ctr      = (frame_ctr + 1) % FP;
    sif.frame_tick = tick;
    sif.btn_start  = btn;
    sif.game_over  = go;
    sif.winner     = w;
    reset_n        = rst_n;
    @(posedge clk);
    model_update(tick, btn, go, w, rst_n);
    last_tick = tick;
    #1;
  endtask

  task automatic idle();
    step(btn_lvl, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic wait_pos(input int k);
    for (int i = 0; i < FP; i++) begin
      if (frame_ctr == k) break;
      idle();
    end
  endtask

  task automatic wait_tick();
    for (int i = 0; i < FP; i++) begin
      idle();
      if (last_tick) break;
    end
  endtask

  task automatic test_reset();
    btn_lvl = 1'b1;
    step(1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b1, 1'b0, 2'b00, 1'b0);
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", obs, 5'b00000);
    end
    for (int i = 0; i < 5 * FP; i++) begin
      idle();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("FAIL held_btn_no_start cycle=%0d got=%b want=%b", i, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_start();
    btn_lvl = 1'b0;
    wait_pos(3);
    btn_lvl = 1'b1;
    idle();
    wait_tick();
    checks++;
    if (obs !== 5'b10001) begin
      failures++;
      $display("FAIL start_play_pulse got=%b want=%b", obs, 5'b10001);
    end
    idle();
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL new_game_one_cycle got=%b want=%b", obs, 5'b10000);
    end
  endtask

  task automatic test_win_hold();
    int count;
    wait_pos(5);
    step(btn_lvl, 1'b1, 2'b10, 1'b1);
    checks++;
    if (obs !== 5'b10100) begin
      failures++;
      $display("FAIL winner_latch got=%b want=%b", obs, 5'b10100);
    end
    wait_tick();
    checks++;
    if (obs !== 5'b01100) begin
      failures++;
      $display("FAIL win_screen_entry got=%b want=%b", obs, 5'b01100);
    end
    count = 1;
    for (int i = 0; i < 10 * FP; i++) begin
      idle();
      if (!sif.ceSS) break;
      count++;
    end
    checks++;
    if (count != WF * FP) begin
      failures++;
      $display("FAIL win_hold_cycles got=%0d want=%0d", count, WF * FP);
    end
    checks++;
    if (obs !== 5'b00100) begin
      failures++;
      $display("FAIL idle_after_win got=%b want=%b", obs, 5'b00100);
    end
  endtask

  task automatic test_tick_coincide();
    btn_lvl = 1'b0;
    idle();
    wait_pos(3);
    btn_lvl = 1'b1;
    idle();
    wait_tick();
    checks++;
    if (obs !== 5'b10101) begin
      failures++;
      $display("FAIL replay_from_idle got=%b want=%b", obs, 5'b10101);
    end
    wait_pos(FP - 1);
    step(btn_lvl, 1'b1, 2'b11, 1'b1);
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL game_over_on_tick got=%b want=%b", obs, 5'b10000);
    end
    wait_pos(5);
    step(btn_lvl, 1'b1, 2'b01, 1'b1);
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL second_game_over_ignored got=%b want=%b", obs, 5'b10000);
    end
    wait_tick();
    checks++;
    if (obs !== 5'b01000) begin
      failures++;
      $display("FAIL delayed_win_entry got=%b want=%b", obs, 5'b01000);
    end
  endtask

  task automatic test_early_exit();
    btn_lvl = 1'b0;
    wait_tick();
    wait_pos(8);
    btn_lvl = 1'b1;
    idle();
    checks++;
    if (obs !== 5'b01000) begin
      failures++;
      $display("FAIL win_before_exit got=%b want=%b", obs, 5'b01000);
    end
    wait_tick();
    checks++;
    if (obs !== 5'b10001) begin
      failures++;
      $display("FAIL early_exit_to_play got=%b want=%b", obs, 5'b10001);
    end
    idle();
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL early_exit_pulse_end got=%b want=%b", obs, 5'b10000);
    end
  endtask

  task automatic test_mid_reset();
    wait_pos(5);
    step(btn_lvl, 1'b1, 2'b01, 1'b1);
    wait_tick();
    wait_tick();
    wait_tick();
    wait_pos(10);
    checks++;
    if (obs !== 5'b01010) begin
      failures++;
      $display("FAIL win_before_reset got=%b want=%b", obs, 5'b01010);
    end
    step(btn_lvl, 1'b0, 2'b00, 1'b0);
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("FAIL mid_reset got=%b want=%b", obs, 5'b00000);
    end
    btn_lvl = 1'b0;
    idle();
    btn_lvl = 1'b1;
    idle();
    wait_tick();
    checks++;
    if (obs !== 5'b10001) begin
      failures++;
      $display("FAIL play_after_reset got=%b want=%b", obs, 5'b10001);
    end
  endtask

  task automatic test_random();
    bit         go, rst_n;
    logic [1:0] w;
    rand_tick = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_lvl = ~btn_lvl;
      go    = ($urandom_range(0, 7) == 0);
      w     = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 499) != 0);
      step(btn_lvl, go, w, rst_n);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random_vs_model cycle=%0d got=%b want=%b", i, obs, exp_vec());
      end
      checks++;
      if (sif.cePS && sif.ceSS) begin
        failures++;
        $display("FAIL enables_exclusive cycle=%0d got=11 want=not both", i);
      end
    end
    rand_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start();
    test_win_hold();
    test_tick_coincide();
    test_early_exit();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Game-flow controller for the TicTacToe VGA path; sits directly upstream of the screen decoder and drives its play-screen enable (cePS) and win-screen enable (ceSS).
- Sequences idle/blank → play → win screen → idle.
- All screen changes are deferred to frame boundaries so the display never switches mid-frame.
- Latches the winner for the win-screen generator and issues a one-cycle new_game pulse to clear the board logic.

Parameters:
- WIN_FRAMES, 180, number of frames the win screen is held; 3 s at 60 Hz; legal range 1..2^CNT_W.
- CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn_start  in  1  debounced start button, level
- game_over  in  1  one-cycle pulse from the board logic when a game ends
- winner  in  2  valid with game_over: 00 draw, 01 X, 10 O, 11 reserved (treated as draw)
- cePS  out  1  play screen enable
- ceSS  out  1  win screen enable
- winner_q  out  2  latched winner, held stable while ceSS=1
- new_game  out  1  one-cycle board-clear pulse

Behaviour:
- Single clock clk. Reset is synchronous and active-low on reset_n, sampled on the clk rising edge.
- Reset values: state IDLE, cePS=0, ceSS=0, winner_q=00, new_game=0, counter=0, both pending flags=0, btn_q=1.
  - btn_q=1 means a button held through reset does not produce a start edge.
- Start edge: start_edge = btn_start & ~btn_q, with btn_q a one-cycle-delayed copy of btn_start.
- Request flags:
  - pend_play is set by start_edge in IDLE or WIN_SHOW.
  - pend_win is set by game_over in PLAY, which also loads winner_q (11 → 00).
  - Both flags are registered, so a request is honoured at the first frame_tick strictly after the request cycle.
  - A request coincident with frame_tick therefore takes effect one frame later.
  - Both flags clear when the transition they requested occurs.
- States and transitions (evaluated only in cycles with frame_tick=1 unless noted):
  - IDLE:
    - If pend_play: go to PLAY and assert new_game.
    - While in IDLE, cePS=0 and ceSS=0, so the decoder shows blank.
  - PLAY:
    - If pend_win: go to WIN_SHOW with counter=0.
    - game_over while pend_win is already set is ignored; the first winner is kept.
    - start_edge in PLAY is ignored.
  - WIN_SHOW, on each frame_tick:
    - If pend_play: go to PLAY and assert new_game (early exit).
    - Else if counter==WIN_FRAMES-1: go to IDLE.
    - Else: counter+1.
    - game_over in WIN_SHOW is ignored.
    - With WIN_FRAMES=1, the win screen lasts exactly one frame.
- Outputs are registered, decoded from the next state:
  - cePS=1 only in PLAY; ceSS=1 only in WIN_SHOW. They are never both 1.
  - Output change occurs one cycle after the frame_tick cycle.
  - new_game is high for exactly that same cycle, coincident with the cePS rising edge.
- winner_q holds its value through IDLE. It is reloaded only by an accepted game_over.
- Reset asserted mid-operation, in any state and at any counter value, returns all outputs to reset values on the next clk edge. No partial transition completes.
- Counter never wraps. It is only compared for equality with WIN_FRAMES-1 and is cleared on WIN_SHOW entry.

Decomposition:
- Shared package contains:
  - state encoding localparams: IDLE=2'd0, PLAY=2'd1, WIN_SHOW=2'd2
  - winner codes: WIN_DRAW=2'b00, WIN_X=2'b01, WIN_O=2'b10
- These are shared with the win-screen generator.
- One natural sub-module: rise_detect (button edge detector with reset-to-1 history register). Reusable for other debounced inputs.

Test Plan (WIN_FRAMES=4, frame_tick every 20 clk):
- Reset with btn_start held high, release reset → no new_game, cePS=0 and ceSS=0 for 5 frames.
- Start edge at clk 3 → cePS=1 and new_game=1 exactly one cycle after the frame_tick at clk 20; new_game returns to 0 next cycle.
- In PLAY, game_over with winner=10 → winner_q=10 next cycle. At the next frame_tick, ceSS=1 and cePS=0. ceSS stays 1 for 4 frames, then IDLE with both enables 0.
- game_over in the same cycle as a frame_tick → ceSS rises one frame later, after the following tick. A second game_over with winner=01 before that tick → winner_q stays 10.
- Start edge during frame 2 of WIN_SHOW → at the next frame_tick, ceSS=0, cePS=1, new_game pulse. winner_q is unchanged.
- reset_n=0 for one cycle mid-WIN_SHOW with counter=2 → all outputs at reset values next cycle. A subsequent start edge returns to PLAY normally.
